alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Registered, parametrised operand-select stage between decode and the ALU in the riscv_core pipeline.
- Picks ALU operand A/B from register file, PC, zero or decoded immediates (I/S/B/U/UJ).
- Resolves RAW hazards in hardware by comparing rs1/rs2 against NUM_FW forwarding ports. Forwarding is not steered by the decoder.
- Operands are registered behind a valid/ready handshake with stall hold, flush and a sticky illegal-select flag.

Parameters:
- XLEN, 32, datapath width of operands, PC, rd1/rd2 and forwarded data (>=32).
- NUM_FW, 2, number of forwarding sources; index 0 is the youngest and has the highest priority.
- SEL_W, 3, width of the operand select inputs.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- instruction  input  32  raw instruction word.
- sel_a  input  SEL_W  operand A select: 0 RF, 1 PC, 2 ZERO, others illegal.
- sel_b  input  SEL_W  operand B select: 0 RF, 1 IMM_I, 2 IMM_S, 3 IMM_B, 4 IMM_U, 5 IMM_UJ, 6 ZERO, 7 illegal.
- rd1  input  XLEN  register file read of rs1.
- rd2  input  XLEN  register file read of rs2.
- pc  input  XLEN  PC of the instruction.
- fw_valid  input  NUM_FW  forwarding entry i carries a pending writeback.
- fw_rd  input  NUM_FW*5  destination register of entry i, packed at [5i+4:5i].
- fw_data  input  NUM_FW*XLEN  result of entry i, packed at [XLEN*i+XLEN-1:XLEN*i].
- flush  input  1  kill the held operand and any accept in the same cycle.
- out_valid  output  1  alu_in_1/alu_in_2 hold a valid operand pair.
- out_ready  input  1  ALU consumes this cycle.
- alu_in_1  output  XLEN  registered operand A.
- alu_in_2  output  XLEN  registered operand B.
- fw_hit  output  2  registered; bit0 means A was forwarded, bit1 means B was forwarded.
- sel_err  output  1  sticky flag, set on an accepted illegal select.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, alu_in_1=0, alu_in_2=0, fw_hit=0, sel_err=0.
  - Outputs stay at these values while rst_n is low.
  - Reset mid-transfer drops the held pair and does not replay it.
- Immediates are decoded combinationally from instruction and sign-extended from bit 31 to XLEN:
  - I = inst[31:20].
  - S = inst[31:25], inst[11:7].
  - B = inst[31], inst[7], inst[30:25], inst[11:8], 0.
  - U = inst[31:12], 12'b0, sign-extended above bit 31.
  - UJ = inst[31], inst[19:12], inst[20], inst[30:21], 0.
- rs1 = inst[19:15], rs2 = inst[24:20].
- Forwarding is applied only when the select is RF (sel_a==0 for A, sel_b==0 for B):
  - Candidate i matches when fw_valid[i] and fw_rd[i]==rsX and rsX!=0.
  - The lowest matching i wins and its fw_data is used; otherwise rd1/rd2 is used.
  - A and B are resolved independently, so both may hit the same entry.
  - The matching fw_hit bit is set with the registered data.
  - x0 is never forwarded: a read of x0 returns rd1/rd2 unchanged.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
  - Accept = in_valid && in_ready && !flush. On accept, alu_in_*, fw_hit and out_valid=1 load at the next edge. Latency is 1 cycle from accept to out_valid.
  - If out_valid && out_ready && !accept, then out_valid goes to 0; data registers keep their last value.
  - If out_valid && !out_ready, the stage stalls. alu_in_1, alu_in_2 and fw_hit are held bit-stable and in_ready=0.
  - Forwarded values are captured at accept time only. Changes on fw_* during a stall do not alter held operands.
- Flush:
  - flush=1 forces out_valid=0 at the next edge regardless of in_valid/out_ready.
  - Data registers are unchanged, and the instruction offered that cycle is not accepted.
  - flush takes priority over simultaneous accept and consume.
- Illegal select (sel_a>=3 or sel_b==7):
  - The affected operand loads 0.
  - sel_err sets to 1 on accept and stays set until reset.
  - The transfer still completes with out_valid=1.
- Arithmetic is pure selection with no truncation. PC and rd inputs are full XLEN; immediates are extended to XLEN.

Test Plan:
- Reset, then sel_a=0 RF and sel_b=1 IMM_I, inst=0xFFF00093 (addi x1,x0,-1), rd1=0x5 -> one cycle after accept: out_valid=1, alu_in_1=0x5, alu_in_2=0xFFFFFFFF, fw_hit=00.
- Forward priority: rs1=x3, fw_valid=11, fw_rd0=fw_rd1=3, fw_data0=0xAA, fw_data1=0xBB, rd1=0x11 -> alu_in_1=0xAA, fw_hit[0]=1. Same stimulus with rs1=x0 -> alu_in_1=rd1, fw_hit[0]=0.
- Stall hold: accept a pair with out_ready=0 for 3 cycles while changing rd1/fw_data -> alu_in_* constant and in_ready=0. Then out_ready=1 with in_valid=1 -> new pair loaded next edge, out_valid stays 1, no bubble.
- Flush priority: out_valid=1, in_valid=1, out_ready=1, flush=1 -> next edge out_valid=0 and the offered instruction is dropped (no out_valid the following cycle without re-offer).
- Immediates: inst=0xFE000FE3 with sel_b=3 -> alu_in_2=0xFFFFFFFE. sel_b=5 with inst=0x800000EF -> alu_in_2=0xFFF00000. sel_b=4 with inst=0xABCDE0B7 -> 0xABCDE000.
- Illegal select and async reset: sel_a=5 accepted -> alu_in_1=0 and sel_err=1, held across later legal transfers. Then drop rst_n mid-stall asynchronously -> out_valid, sel_err and alu_in_* clear immediately without waiting for a clk edge.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Bundle of decode-side, forwarding and ALU-side signals for the ALU operand stage.
// Ports (all logic):
//   in_valid, instruction, sel_a, sel_b, rd1, rd2, pc  : decode -> stage
//   in_ready                                           : stage -> decode
//   fw_valid, fw_rd, fw_data                           : forwarding sources -> stage
//   flush                                              : pipeline control -> stage
//   out_valid, alu_in_1, alu_in_2, fw_hit, sel_err     : stage -> ALU
//   out_ready                                          : ALU -> stage
// master is the environment side (decode + ALU), slave is the operand stage.
interface alu_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int NUM_FW = 2,
  parameter int SEL_W  = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            instruction;
  logic [SEL_W-1:0]       sel_a;
  logic [SEL_W-1:0]       sel_b;
  logic [XLEN-1:0]        rd1;
  logic [XLEN-1:0]        rd2;
  logic [XLEN-1:0]        pc;
  logic [NUM_FW-1:0]      fw_valid;
  logic [NUM_FW*5-1:0]    fw_rd;
  logic [NUM_FW*XLEN-1:0] fw_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        alu_in_1;
  logic [XLEN-1:0]        alu_in_2;
  logic [1:0]             fw_hit;
  logic                   sel_err;

  modport master (
    output in_valid, instruction, sel_a, sel_b, rd1, rd2, pc,
           fw_valid, fw_rd, fw_data, flush, out_ready,
    input  in_ready, out_valid, alu_in_1, alu_in_2, fw_hit, sel_err
  );

  modport slave (
    input  in_valid, instruction, sel_a, sel_b, rd1, rd2, pc,
           fw_valid, fw_rd, fw_data, flush, out_ready,
    output in_ready, out_valid, alu_in_1, alu_in_2, fw_hit, sel_err
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered operand-select stage between decode and the ALU.
// Selects operand A (RF / PC / zero) and operand B (RF / I,S,B,U,UJ immediates / zero),
// resolves RAW hazards against NUM_FW forwarding entries (index 0 youngest, highest
// priority) and registers the pair behind a valid/ready handshake with stall hold,
// flush and a sticky illegal-select flag.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_operand_stage_if.slave (handshake, operands, forwarding, status)
// Parameters must match those of the connected interface instance.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int NUM_FW = 2,
  parameter int SEL_W  = 3
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_stage_if.slave bus
);

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] inst);
    logic signed [11:0] v;
    v = inst[31:20];
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] inst);
    logic signed [11:0] v;
    v = {inst[31:25], inst[11:7]};
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] inst);
    logic signed [12:0] v;
    v = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] inst);
    logic signed [31:0] v;
    v = {inst[31:12], 12'b0};
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] imm_uj(input logic [31:0] inst);
    logic signed [20:0] v;
    v = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return XLEN'(v);
  endfunction

  // Returns {hit, data}. Walking from the oldest entry to the youngest lets the
  // lowest matching index overwrite any older match.
  function automatic logic [XLEN:0] resolve_fw(
    input logic [4:0]             rs,
    input logic [XLEN-1:0]        rf,
    input logic [NUM_FW-1:0]      v,
    input logic [NUM_FW*5-1:0]    rd,
    input logic [NUM_FW*XLEN-1:0] d
  );
    logic [XLEN:0] r;
    r = {1'b0, rf};
    for (int i = NUM_FW - 1; i >= 0; i--) begin
      if (v[i] && (rd[5*i +: 5] == rs) && (rs != 5'd0)) begin
        r = {1'b1, d[XLEN*i +: XLEN]};
      end
    end
    return r;
  endfunction

  logic [4:0]      rs1, rs2;
  logic [XLEN:0]   fw_a, fw_b;
  logic [XLEN-1:0] op_a, op_b;
  logic            hit_a, hit_b;
  logic            err_a, err_b;
  logic            accept;

  logic            out_valid_q, out_valid_d;
  logic            sel_err_q, sel_err_d;
  logic [XLEN-1:0] alu_in_1_q, alu_in_1_d;
  logic [XLEN-1:0] alu_in_2_q, alu_in_2_d;
  logic [1:0]      fw_hit_q, fw_hit_d;

  assign rs1 = bus.instruction[19:15];
  assign rs2 = bus.instruction[24:20];

  assign fw_a = resolve_fw(rs1, bus.rd1, bus.fw_valid, bus.fw_rd, bus.fw_data);
  assign fw_b = resolve_fw(rs2, bus.rd2, bus.fw_valid, bus.fw_rd, bus.fw_data);

  // Operand select: forwarding only participates on the RF path.
  always_comb begin
    op_a  = '0;
    hit_a = 1'b0;
    err_a = 1'b0;
    case (bus.sel_a)
      SEL_W'(0): begin
        op_a  = fw_a[XLEN-1:0];
        hit_a = fw_a[XLEN];
      end
      SEL_W'(1): op_a = bus.pc;
      SEL_W'(2): op_a = '0;
      default:   err_a = 1'b1;
    endcase
  end

  always_comb begin
    op_b  = '0;
    hit_b = 1'b0;
    err_b = 1'b0;
    case (bus.sel_b)
      SEL_W'(0): begin
        op_b  = fw_b[XLEN-1:0];
        hit_b = fw_b[XLEN];
      end
      SEL_W'(1): op_b = imm_i(bus.instruction);
      SEL_W'(2): op_b = imm_s(bus.instruction);
      SEL_W'(3): op_b = imm_b(bus.instruction);
      SEL_W'(4): op_b = imm_u(bus.instruction);
      SEL_W'(5): op_b = imm_uj(bus.instruction);
      SEL_W'(6): op_b = '0;
      default:   err_b = 1'b1;
    endcase
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Flush beats accept and consume; a stalled pair keeps its data bit-stable.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_in_1_d  = alu_in_1_q;
    alu_in_2_d  = alu_in_2_q;
    fw_hit_d    = fw_hit_q;
    sel_err_d   = sel_err_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_in_1_d  = op_a;
      alu_in_2_d  = op_b;
      fw_hit_d    = {hit_b, hit_a};
      sel_err_d   = sel_err_q || err_a || err_b;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ---- operand register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_in_1_q  <= '0;
      alu_in_2_q  <= '0;
      fw_hit_q    <= 2'b00;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_in_1_q  <= alu_in_1_d;
      alu_in_2_q  <= alu_in_2_d;
      fw_hit_q    <= fw_hit_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_in_1  = alu_in_1_q;
  assign bus.alu_in_2  = alu_in_2_q;
  assign bus.fw_hit    = fw_hit_q;
  assign bus.sel_err   = sel_err_q;

endmodule
